// File: rtl/countdown_timer_pkg.sv
// Shared widths, digit limits, state encodings and BCD helpers for the countdown timer.
package countdown_timer_pkg;

    localparam int unsigned DIG_W      = 4;
    localparam int unsigned N_DIG      = 4;
    localparam int unsigned TIME_W     = DIG_W * N_DIG;
    localparam int unsigned DIG_L_ONES = 10;
    localparam int unsigned DIG_L_TENS = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // MM:SS packed the same way as load_val / digits
    typedef struct packed {
        logic [DIG_W-1:0] m_tens;
        logic [DIG_W-1:0] m_ones;
        logic [DIG_W-1:0] s_tens;
        logic [DIG_W-1:0] s_ones;
    } bcd_time_t;

    // Saturate one digit to lim-1 when it is out of range
    function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] a,
                                                     input logic [DIG_W-1:0] lim);
        return (a >= lim) ? (lim - DIG_W'(1)) : a;
    endfunction

    // Clamp every digit of a preset to its legal range
    function automatic bcd_time_t clamp_time(input bcd_time_t t);
        bcd_time_t r;
        r.m_tens = clamp_digit(t.m_tens, DIG_W'(DIG_L_TENS));
        r.m_ones = clamp_digit(t.m_ones, DIG_W'(DIG_L_ONES));
        r.s_tens = clamp_digit(t.s_tens, DIG_W'(DIG_L_TENS));
        r.s_ones = clamp_digit(t.s_ones, DIG_W'(DIG_L_ONES));
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_lim_dec.sv
// Combinational saturating BCD digit decrement with borrow in/out.
module countdown_timer_lim_dec
    import countdown_timer_pkg::*;
#(
    parameter int unsigned L = 10
) (
    input  logic [DIG_W-1:0] a,
    input  logic             bi,
    output logic [DIG_W-1:0] diff,
    output logic             bo
);

    localparam logic [DIG_W-1:0] L_LIM = DIG_W'(L);
    localparam logic [DIG_W-1:0] L_TOP = DIG_W'(L - 1);

    // Borrow-driven decrement; out-of-range digits saturate without borrowing
    always_comb begin
        diff = a;
        bo   = 1'b0;
        if (bi) begin
            if (a >= L_LIM) begin
                diff = L_TOP;
            end else if (a == '0) begin
                diff = L_TOP;
                bo   = 1'b1;
            end else begin
                diff = a - DIG_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: load a preset, count down once per tick, stop at 00:00 and pulse done.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              start_stop,
    output logic [TIME_W-1:0] digits,
    output logic              running,
    output logic              done
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [1:0]       state_q, state_d;
    bcd_time_t        count_q, count_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             done_q, done_d;
    logic             running_q, running_d;

    bcd_time_t        dec;
    logic             b_s_ones, b_s_tens, b_m_ones, b_m_tens;
    logic             tick;
    logic             is_last;

    // Borrow chain: seconds ones always borrows, each digit feeds the next
    countdown_timer_lim_dec #(.L(DIG_L_ONES)) u_s_ones (
        .a(count_q.s_ones), .bi(1'b1),     .diff(dec.s_ones), .bo(b_s_ones)
    );
    countdown_timer_lim_dec #(.L(DIG_L_TENS)) u_s_tens (
        .a(count_q.s_tens), .bi(b_s_ones), .diff(dec.s_tens), .bo(b_s_tens)
    );
    countdown_timer_lim_dec #(.L(DIG_L_ONES)) u_m_ones (
        .a(count_q.m_ones), .bi(b_s_tens), .diff(dec.m_ones), .bo(b_m_ones)
    );
    countdown_timer_lim_dec #(.L(DIG_L_TENS)) u_m_tens (
        .a(count_q.m_tens), .bi(b_m_ones), .diff(dec.m_tens), .bo(b_m_tens)
    );

    assign tick    = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);
    assign is_last = (count_q == TIME_W'(16'h0001));

    // Next-state and next-output logic; priority clear > load > start_stop > tick
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tick_cnt_d = tick_cnt_q;
        done_d     = 1'b0;
        if (clear) begin
            count_d    = '0;
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
        end else if (load) begin
            count_d    = clamp_time(bcd_time_t'(load_val));
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_d    = ST_RUN;
                        tick_cnt_d = '0;
                    end
                end
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                end
                default:  state_d = state_q;
            endcase
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                tick_cnt_d = '0;
                // A borrow out of the top digit means 00:00, which is a hold point
                if (!b_m_tens) begin
                    count_d = dec;
                end
                if (is_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
        end
        running_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tick_cnt_q <= tick_cnt_d;
            done_q     <= done_d;
            running_q  <= running_d;
        end
    end

    assign digits  = count_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, corner sequences, random vs seconds model.
module tb_countdown_timer;

    localparam int TD = 4;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic        start_stop;
    logic [15:0] digits;
    logic        running;
    logic        done;

    int total = 0;
    int bad   = 0;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load(load),
        .load_val(load_val), .start_stop(start_stop),
        .digits(digits), .running(running), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    // Reference model: time held as a plain seconds count
    typedef enum {M_STOPPED, M_COUNTING, M_HELD, M_FINISHED} mode_t;
    mode_t m_mode;
    int    m_secs;
    int    m_phase;
    bit    m_done;

    function automatic logic [15:0] to_bcd(input int secs);
        logic [15:0] r;
        r[15:12] = 4'(secs / 600);
        r[11:8]  = 4'((secs / 60) % 10);
        r[7:4]   = 4'((secs % 60) / 10);
        r[3:0]   = 4'(secs % 10);
        return r;
    endfunction

    function automatic int lim(input int d, input int l);
        return (d >= l) ? l - 1 : d;
    endfunction

    function automatic int load_secs(input logic [15:0] v);
        int mt, mo, st, so;
        mt = lim(int'(v[15:12]), 6);
        mo = lim(int'(v[11:8]), 10);
        st = lim(int'(v[7:4]), 6);
        so = lim(int'(v[3:0]), 10);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    task automatic model_reset();
        m_mode = M_STOPPED; m_secs = 0; m_phase = 0; m_done = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit l, input logic [15:0] v, input bit s);
        m_done = 1'b0;
        if (c) begin
            m_secs = 0; m_mode = M_STOPPED;
        end else if (l) begin
            m_secs = load_secs(v); m_mode = M_STOPPED;
        end else if (s) begin
            case (m_mode)
                M_STOPPED:  if (m_secs != 0) begin m_mode = M_COUNTING; m_phase = 0; end
                M_COUNTING: m_mode = M_HELD;
                M_HELD:     begin m_mode = M_COUNTING; m_phase = 0; end
                default:    ;
            endcase
        end else if (m_mode == M_COUNTING) begin
            if (m_phase == TD - 1) begin
                m_phase = 0;
                m_secs  = m_secs - 1;
                if (m_secs == 0) begin m_mode = M_FINISHED; m_done = 1'b1; end
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, step model at the edge, compare 1 time unit later
    task automatic cyc(input bit c, input bit l, input logic [15:0] v, input bit s);
        clear = c; load = l; load_val = v; start_stop = s;
        @(posedge clk);
        model_step(c, l, v, s);
        #1;
        chk("mdl_digits", int'(digits), int'(to_bcd(m_secs)));
        chk("mdl_running", int'(running), int'(m_mode == M_COUNTING));
        chk("mdl_done", int'(done), int'(m_done));
        clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // Async reset: outputs must clear before any clock edge
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        chk({name, "_digits"}, int'(digits), 0);
        chk({name, "_running"}, int'(running), 0);
        chk({name, "_done"}, int'(done), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          c;
        bit          l;
        logic [15:0] v;
        bit          s;
        logic [15:0] ed;
        bit          er;
        bit          edn;
    } vec_t;

    vec_t vecs[14];

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0; start_stop = 1'b0;
        model_reset();
        vecs[0]  = '{1'b0, 1'b1, 16'h7A9F, 1'b0, 16'h5959, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h5959, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0102, 1'b0, 16'h0102, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        do_reset("rst_init");

        // Vector table
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].c, vecs[i].l, vecs[i].v, vecs[i].s);
            chk($sformatf("vec%0d_digits", i), int'(digits), int'(vecs[i].ed));
            chk($sformatf("vec%0d_running", i), int'(running), int'(vecs[i].er));
            chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].edn));
        end

        // Full countdown from 01:02
        cyc(1'b0, 1'b1, 16'h0102, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int k = 1; k <= 62; k++) begin
            idle(3);
            chk("cd_hold", int'(digits), int'(to_bcd(62 - k + 1)));
            idle(1);
            chk("cd_step", int'(digits), int'(to_bcd(62 - k)));
            if (k == 1) chk("cd_0101", int'(digits), 16'h0101);
            if (k == 2) chk("cd_0100", int'(digits), 16'h0100);
            if (k == 3) chk("cd_0059", int'(digits), 16'h0059);
            chk("cd_done", int'(done), int'(k == 62));
        end
        idle(1);
        chk("cd_done_clr", int'(done), 0);
        chk("cd_end_run", int'(running), 0);

        // 10:00 wrap, pause hold, resume
        cyc(1'b0, 1'b1, 16'h1000, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(4);
        chk("wrap_0959", int'(digits), 16'h0959);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("pause_run", int'(running), 0);
        idle(10);
        chk("pause_hold", int'(digits), 16'h0959);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("resume_run", int'(running), 1);
        idle(3);
        chk("resume_wait", int'(digits), 16'h0959);
        idle(1);
        chk("resume_0958", int'(digits), 16'h0958);

        // start_stop on the final tick wins
        cyc(1'b0, 1'b1, 16'h0001, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(3);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("race_digits", int'(digits), 16'h0001);
        chk("race_done", int'(done), 0);
        chk("race_run", int'(running), 0);
        idle(6);
        chk("race_hold", int'(digits), 16'h0001);

        // load beats start_stop during RUN; clear beats load
        cyc(1'b0, 1'b1, 16'h0500, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(2);
        cyc(1'b0, 1'b1, 16'h0230, 1'b1);
        chk("ldss_digits", int'(digits), 16'h0230);
        chk("ldss_run", int'(running), 0);
        cyc(1'b1, 1'b1, 16'h0230, 1'b0);
        chk("clrld_digits", int'(digits), 16'h0000);

        // Reset mid-count
        cyc(1'b0, 1'b1, 16'h0300, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(5);
        do_reset("rst_mid");
        idle(6);
        chk("rst_after_run", int'(running), 0);
        chk("rst_after_dig", int'(digits), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          rc, rl, rs;
            logic [15:0] rv;
            rc = ($urandom_range(63) == 0);
            rl = ($urandom_range(15) == 0);
            rs = ($urandom_range(7) == 0);
            rv = 16'($urandom);
            if ($urandom_range(1) == 0) rv = to_bcd(int'($urandom_range(8)));
            cyc(rc, rl, rv, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
